// File: rtl/bimodal_predictor_if.sv
// rtl/bimodal_predictor_if.sv - fetch/execute side bus of the bimodal branch predictor
interface bimodal_predictor_if #(
    parameter int PC_W       = 32,
    parameter int PEND_DEPTH = 4
);
    localparam int CNT_W = $clog2(PEND_DEPTH) + 1;

    logic              req;
    logic [PC_W-1:0]   req_pc;
    logic              req_ready;
    logic              pred_valid;
    logic              pred_taken;
    logic              res;
    logic              res_taken;
    logic              res_drop;
    logic [CNT_W-1:0]  pend_cnt;

    modport master (
        output req, req_pc, res, res_taken,
        input  req_ready, pred_valid, pred_taken, res_drop, pend_cnt
    );

    modport slave (
        input  req, req_pc, res, res_taken,
        output req_ready, pred_valid, pred_taken, res_drop, pend_cnt
    );
endinterface

// File: rtl/bimodal_predictor.sv
// rtl/bimodal_predictor.sv - PC-indexed table of saturating counters with in-flight prediction FIFO
// Optional GSHARE_EN: XOR the table index with a non-speculative global history register.
module bimodal_predictor #(
    parameter int PC_W       = 32,
    parameter int IDX_W      = 4,
    parameter int CTR_W      = 2,
    parameter int CTR_INIT   = (1 << CTR_W) - 1,
    parameter int PEND_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bimodal_predictor_if.slave   bus
);
    localparam int N_ENT = 1 << IDX_W;
    localparam int PTR_W = $clog2(PEND_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'((1 << CTR_W) - 1);

    logic [CTR_W-1:0] r_table [N_ENT];
    logic [IDX_W-1:0] r_fifo  [PEND_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pred_valid;
    logic             r_pred_taken;
    logic             r_res_drop;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic [CTR_W-1:0] w_cur_ctr;
    logic [CTR_W-1:0] w_upd_ctr;
    logic             w_unused;

    // Full/empty come from registered occupancy only, so a pop never frees a slot in the same cycle.
    assign w_full  = (r_cnt == CNT_W'(PEND_DEPTH));
    assign w_empty = (r_cnt == '0);
    assign w_push  = bus.req && !w_full;
    assign w_pop   = bus.res && !w_empty;

`ifdef GSHARE_EN
    logic [IDX_W-1:0] r_ghr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ghr <= '0;
        end else if (w_pop) begin
            r_ghr <= {r_ghr[IDX_W-2:0], bus.res_taken};
        end
    end

    assign w_idx = bus.req_pc[IDX_W+1:2] ^ r_ghr;
`else
    assign w_idx = bus.req_pc[IDX_W+1:2];
`endif

    assign w_unused  = ^{bus.req_pc[PC_W-1:IDX_W+2], bus.req_pc[1:0]};
    assign w_upd_idx = r_fifo[r_rptr];
    assign w_cur_ctr = r_table[w_upd_idx];

    always_comb begin
        w_upd_ctr = w_cur_ctr;
        if (bus.res_taken) begin
            if (w_cur_ctr != CTR_MAX) w_upd_ctr = w_cur_ctr + CTR_W'(1);
        end else begin
            if (w_cur_ctr != '0) w_upd_ctr = w_cur_ctr - CTR_W'(1);
        end
    end

    // Prediction reads the pre-update counter: no bypass from a same-cycle result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ENT; i++) r_table[i] <= CTR_W'(CTR_INIT);
        end else if (w_pop) begin
            r_table[w_upd_idx] <= w_upd_ctr;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= w_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_res_drop   <= 1'b0;
        end else begin
            r_pred_valid <= w_push;
            if (w_push) r_pred_taken <= r_table[w_idx][CTR_W-1];
            r_res_drop   <= bus.res && w_empty;
        end
    end

    assign bus.req_ready  = !w_full;
    assign bus.pred_valid = r_pred_valid;
    assign bus.pred_taken = r_pred_taken;
    assign bus.res_drop   = r_res_drop;
    assign bus.pend_cnt   = r_cnt;
endmodule

// File: tb/tb_bimodal_predictor.sv
// tb/tb_bimodal_predictor.sv - directed self-checking bench for bimodal_predictor
module tb_bimodal_predictor;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    bimodal_predictor_if #(.PC_W(32), .PEND_DEPTH(4)) ifc ();

    bimodal_predictor #(
        .PC_W(32), .IDX_W(4), .CTR_W(2), .CTR_INIT(3), .PEND_DEPTH(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ifc.req = 1'b0; ifc.req_pc = '0; ifc.res = 1'b0; ifc.res_taken = 1'b0;
        tick(); tick();
        vectors++;
        if (ifc.pend_cnt !== 3'd0) begin miscompares++; $display("FAIL reset_pend_cnt got %0d want 0", ifc.pend_cnt); end
        vectors++;
        if (ifc.req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready got %b want 1", ifc.req_ready); end
        vectors++;
        if ({ifc.pred_valid, ifc.pred_taken, ifc.res_drop} !== 3'b000) begin
            miscompares++; $display("FAIL reset_outputs got %b want 000", {ifc.pred_valid, ifc.pred_taken, ifc.res_drop});
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (ifc.pred_valid !== 1'b0) begin miscompares++; $display("FAIL idle_pred_valid got %b want 0", ifc.pred_valid); end
    endtask

    task automatic test_first_pred;
        ifc.req = 1'b1; ifc.req_pc = 32'h10;
        tick();
        ifc.req = 1'b0;
        vectors++;
        if ({ifc.pred_valid, ifc.pred_taken} !== 2'b11) begin
            miscompares++; $display("FAIL first_pred got %b want 11", {ifc.pred_valid, ifc.pred_taken});
        end
        vectors++;
        if (ifc.pend_cnt !== 3'd1) begin miscompares++; $display("FAIL first_pend_cnt got %0d want 1", ifc.pend_cnt); end
        ifc.res = 1'b1; ifc.res_taken = 1'b1;
        tick();
        ifc.res = 1'b0;
        vectors++;
        if (ifc.pred_valid !== 1'b0) begin miscompares++; $display("FAIL pred_pulse_width got %b want 0", ifc.pred_valid); end
        vectors++;
        if (ifc.pend_cnt !== 3'd0) begin miscompares++; $display("FAIL first_pop_pend got %0d want 0", ifc.pend_cnt); end
    endtask

    task automatic test_saturation;
        logic outc [9];
        logic expp [9];
        outc = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
        expp = '{1, 1, 0, 0, 0, 0, 0, 1, 1};
        for (int k = 0; k < 9; k++) begin
            ifc.req = 1'b1; ifc.req_pc = 32'h10;
            tick();
            ifc.req = 1'b0;
            vectors++;
            if ({ifc.pred_valid, ifc.pred_taken} !== {1'b1, expp[k]}) begin
                miscompares++; $display("FAIL sat_pred step %0d got %b want %b", k, {ifc.pred_valid, ifc.pred_taken}, {1'b1, expp[k]});
            end
            ifc.res = 1'b1; ifc.res_taken = outc[k];
            tick();
            ifc.res = 1'b0;
        end
        ifc.req = 1'b1; ifc.req_pc = 32'h10;
        tick();
        ifc.req = 1'b0;
        vectors++;
        if (ifc.pred_taken !== 1'b1) begin miscompares++; $display("FAIL sat_high got %b want 1", ifc.pred_taken); end
        ifc.res = 1'b1; ifc.res_taken = 1'b1;
        tick();
        ifc.res = 1'b0;
    endtask

    task automatic test_back_to_back_full;
        ifc.req = 1'b1; ifc.req_pc = 32'h10;
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if ({ifc.pred_valid, ifc.pred_taken} !== 2'b11) begin
                miscompares++; $display("FAIL b2b_pred %0d got %b want 11", k, {ifc.pred_valid, ifc.pred_taken});
            end
        end
        vectors++;
        if ({ifc.req_ready, ifc.pend_cnt} !== {1'b0, 3'd4}) begin
            miscompares++; $display("FAIL full_state got ready=%b cnt=%0d want ready=0 cnt=4", ifc.req_ready, ifc.pend_cnt);
        end
        tick();
        vectors++;
        if ({ifc.pred_valid, ifc.pend_cnt} !== {1'b0, 3'd4}) begin
            miscompares++; $display("FAIL full_reject got valid=%b cnt=%0d want valid=0 cnt=4", ifc.pred_valid, ifc.pend_cnt);
        end
        ifc.req = 1'b0; ifc.res = 1'b1; ifc.res_taken = 1'b1;
        tick();
        vectors++;
        if ({ifc.req_ready, ifc.pend_cnt} !== {1'b1, 3'd3}) begin
            miscompares++; $display("FAIL full_pop got ready=%b cnt=%0d want ready=1 cnt=3", ifc.req_ready, ifc.pend_cnt);
        end
        ifc.res = 1'b0; ifc.req = 1'b1;
        tick();
        ifc.res = 1'b1;
        tick();
        vectors++;
        if ({ifc.pred_valid, ifc.pend_cnt} !== {1'b0, 3'd3}) begin
            miscompares++; $display("FAIL full_req_res got valid=%b cnt=%0d want valid=0 cnt=3", ifc.pred_valid, ifc.pend_cnt);
        end
        ifc.req = 1'b0;
        repeat (3) tick();
        ifc.res = 1'b0;
        vectors++;
        if (ifc.pend_cnt !== 3'd0) begin miscompares++; $display("FAIL full_drain got %0d want 0", ifc.pend_cnt); end
    endtask

    task automatic test_drop;
        ifc.res = 1'b1; ifc.res_taken = 1'b0;
        tick();
        vectors++;
        if (ifc.res_drop !== 1'b1) begin miscompares++; $display("FAIL drop_pulse got %b want 1", ifc.res_drop); end
        tick();
        ifc.res = 1'b0;
        tick();
        vectors++;
        if ({ifc.res_drop, ifc.pend_cnt} !== {1'b0, 3'd0}) begin
            miscompares++; $display("FAIL drop_end got drop=%b cnt=%0d want drop=0 cnt=0", ifc.res_drop, ifc.pend_cnt);
        end
        ifc.req = 1'b1; ifc.req_pc = 32'h10;
        tick();
        ifc.req = 1'b0;
        vectors++;
        if (ifc.pred_taken !== 1'b1) begin miscompares++; $display("FAIL drop_table got %b want 1", ifc.pred_taken); end
        ifc.res = 1'b1; ifc.res_taken = 1'b1;
        tick();
        ifc.res = 1'b0;
    endtask

    task automatic test_same_index;
        ifc.req = 1'b1; ifc.req_pc = 32'h20;
        tick();
        ifc.req = 1'b0; ifc.res = 1'b1; ifc.res_taken = 1'b0;
        tick();
        ifc.res = 1'b0; ifc.req = 1'b1;
        tick();
        ifc.res = 1'b1;
        tick();
        vectors++;
        if ({ifc.pred_valid, ifc.pred_taken} !== 2'b11) begin
            miscompares++; $display("FAIL same_idx_old got %b want 11", {ifc.pred_valid, ifc.pred_taken});
        end
        vectors++;
        if (ifc.pend_cnt !== 3'd1) begin miscompares++; $display("FAIL same_idx_cnt got %0d want 1", ifc.pend_cnt); end
        ifc.res = 1'b0; ifc.req_pc = 32'h23;
        tick();
        ifc.req = 1'b0;
        vectors++;
        if ({ifc.pred_taken, ifc.pend_cnt} !== {1'b0, 3'd2}) begin
            miscompares++; $display("FAIL same_idx_new got pred=%b cnt=%0d want pred=0 cnt=2", ifc.pred_taken, ifc.pend_cnt);
        end
        ifc.res = 1'b1; ifc.res_taken = 1'b1;
        tick(); tick();
        ifc.res = 1'b0;
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 2; k++) begin
            ifc.req = 1'b1; ifc.req_pc = 32'h30;
            tick();
            ifc.req = 1'b0; ifc.res = 1'b1; ifc.res_taken = 1'b0;
            tick();
            ifc.res = 1'b0;
        end
        ifc.req = 1'b1;
        tick();
        vectors++;
        if (ifc.pred_taken !== 1'b0) begin miscompares++; $display("FAIL mid_pre_pred got %b want 0", ifc.pred_taken); end
        tick(); tick();
        ifc.req = 1'b0;
        vectors++;
        if (ifc.pend_cnt !== 3'd3) begin miscompares++; $display("FAIL mid_pending got %0d want 3", ifc.pend_cnt); end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({ifc.pend_cnt, ifc.req_ready, ifc.pred_valid} !== {3'd0, 1'b1, 1'b0}) begin
            miscompares++; $display("FAIL async_reset got cnt=%0d ready=%b valid=%b want 0 1 0", ifc.pend_cnt, ifc.req_ready, ifc.pred_valid);
        end
        rst = 1'b0;
        ifc.res = 1'b1; ifc.res_taken = 1'b0;
        tick();
        ifc.res = 1'b0;
        vectors++;
        if ({ifc.res_drop, ifc.pend_cnt} !== {1'b1, 3'd0}) begin
            miscompares++; $display("FAIL post_reset_drop got drop=%b cnt=%0d want drop=1 cnt=0", ifc.res_drop, ifc.pend_cnt);
        end
        ifc.req = 1'b1; ifc.req_pc = 32'h30;
        tick();
        ifc.req = 1'b0;
        vectors++;
        if ({ifc.pred_taken, ifc.pend_cnt} !== {1'b1, 3'd1}) begin
            miscompares++; $display("FAIL post_reset_ctr got pred=%b cnt=%0d want pred=1 cnt=1", ifc.pred_taken, ifc.pend_cnt);
        end
        ifc.res = 1'b1; ifc.res_taken = 1'b1;
        tick();
        ifc.res = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_first_pred();
        test_saturation();
        test_back_to_back_full();
        test_drop();
        test_same_index();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
